// File: rtl/eight_bit_multiplier.sv
// Registered SIMD unsigned multiplier: one 8x8, two 4x4 and four 2x2 lane products per cycle.
// The 8x8 product is composed from 4x4 sub-products, each of which is composed from 2x2 ones.
module eight_bit_multiplier (
  input  logic        CLK,
  input  logic        nrst,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] result,
  output logic [3:0]  result_int2_0,
  output logic [3:0]  result_int2_1,
  output logic [3:0]  result_int2_2,
  output logic [3:0]  result_int2_3,
  output logic [7:0]  result_int4_0,
  output logic [7:0]  result_int4_1
);

  function automatic logic [3:0] mul2(input logic [1:0] x, input logic [1:0] y);
    return {2'b00, x} * {2'b00, y};
  endfunction

  function automatic logic [7:0] compose4(input logic [3:0] p_ll, input logic [3:0] p_hl,
                                          input logic [3:0] p_lh, input logic [3:0] p_hh);
    return {4'h0, p_ll} + (({4'h0, p_hl} + {4'h0, p_lh}) << 2) + ({4'h0, p_hh} << 4);
  endfunction

  function automatic logic [7:0] mul4(input logic [3:0] x, input logic [3:0] y);
    return compose4(mul2(x[1:0], y[1:0]), mul2(x[3:2], y[1:0]),
                    mul2(x[1:0], y[3:2]), mul2(x[3:2], y[3:2]));
  endfunction

  // Diagonal 2x2 sub-products double as the INT2 lane outputs.
  logic [3:0]  w_p2_0, w_p2_1, w_p2_2, w_p2_3;
  logic [7:0]  w_p4_0, w_p4_1, w_p4_hl, w_p4_lh;
  logic [15:0] w_p8;

  assign w_p2_0 = mul2(a[1:0], b[1:0]);
  assign w_p2_1 = mul2(a[3:2], b[3:2]);
  assign w_p2_2 = mul2(a[5:4], b[5:4]);
  assign w_p2_3 = mul2(a[7:6], b[7:6]);

  assign w_p4_0 = compose4(w_p2_0, mul2(a[3:2], b[1:0]), mul2(a[1:0], b[3:2]), w_p2_1);
  assign w_p4_1 = compose4(w_p2_2, mul2(a[7:6], b[5:4]), mul2(a[5:4], b[7:6]), w_p2_3);

  // Cross 4x4 terms feed only the 8x8 composition.
  assign w_p4_hl = mul4(a[7:4], b[3:0]);
  assign w_p4_lh = mul4(a[3:0], b[7:4]);

  assign w_p8 = {8'h00, w_p4_0} + (({8'h00, w_p4_hl} + {8'h00, w_p4_lh}) << 4)
              + ({8'h00, w_p4_1} << 8);

  logic [15:0] r_result;
  logic [3:0]  r_int2_0, r_int2_1, r_int2_2, r_int2_3;
  logic [7:0]  r_int4_0, r_int4_1;

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      r_result <= '0;
      r_int2_0 <= '0;
      r_int2_1 <= '0;
      r_int2_2 <= '0;
      r_int2_3 <= '0;
      r_int4_0 <= '0;
      r_int4_1 <= '0;
    end else begin
      r_result <= w_p8;
      r_int2_0 <= w_p2_0;
      r_int2_1 <= w_p2_1;
      r_int2_2 <= w_p2_2;
      r_int2_3 <= w_p2_3;
      r_int4_0 <= w_p4_0;
      r_int4_1 <= w_p4_1;
    end
  end

  assign result        = r_result;
  assign result_int2_0 = r_int2_0;
  assign result_int2_1 = r_int2_1;
  assign result_int2_2 = r_int2_2;
  assign result_int2_3 = r_int2_3;
  assign result_int4_0 = r_int4_0;
  assign result_int4_1 = r_int4_1;

endmodule

// File: tb/tb_eight_bit_multiplier.sv
// Scoreboard bench for eight_bit_multiplier: driver queues reference products, monitor
// pops and compares one edge after capture.
module tb_eight_bit_multiplier;

  logic        CLK;
  logic        nrst;
  logic [7:0]  a, b;
  logic [15:0] result;
  logic [3:0]  result_int2_0, result_int2_1, result_int2_2, result_int2_3;
  logic [7:0]  result_int4_0, result_int4_1;

  eight_bit_multiplier dut (
    .CLK           (CLK),
    .nrst          (nrst),
    .a             (a),
    .b             (b),
    .result        (result),
    .result_int2_0 (result_int2_0),
    .result_int2_1 (result_int2_1),
    .result_int2_2 (result_int2_2),
    .result_int2_3 (result_int2_3),
    .result_int4_0 (result_int4_0),
    .result_int4_1 (result_int4_1)
  );

  typedef struct packed {
    logic [15:0] r;
    logic [7:0]  i4_1, i4_0;
    logic [3:0]  i2_3, i2_2, i2_1, i2_0;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int unsigned xi = x, yi = y;
    e.r    = 16'(xi * yi);
    e.i4_0 = 8'((xi % 16) * (yi % 16));
    e.i4_1 = 8'((xi / 16) * (yi / 16));
    e.i2_0 = 4'((xi % 4) * (yi % 4));
    e.i2_1 = 4'(((xi / 4) % 4) * ((yi / 4) % 4));
    e.i2_2 = 4'(((xi / 16) % 4) * ((yi / 16) % 4));
    e.i2_3 = 4'((xi / 64) * (yi / 64));
    return e;
  endfunction

  task automatic apply(input logic [7:0] x, input logic [7:0] y);
    @(negedge CLK);
    a = x;
    b = y;
    exp_q.push_back(model(x, y));
  endtask

  task automatic chk_exp(input string tag, input exp_t e);
    chk({tag, ".result"}, result, e.r);
    chk({tag, ".int4_0"}, {8'h00, result_int4_0}, {8'h00, e.i4_0});
    chk({tag, ".int4_1"}, {8'h00, result_int4_1}, {8'h00, e.i4_1});
    chk({tag, ".int2_0"}, {12'h000, result_int2_0}, {12'h000, e.i2_0});
    chk({tag, ".int2_1"}, {12'h000, result_int2_1}, {12'h000, e.i2_1});
    chk({tag, ".int2_2"}, {12'h000, result_int2_2}, {12'h000, e.i2_2});
    chk({tag, ".int2_3"}, {12'h000, result_int2_3}, {12'h000, e.i2_3});
  endtask

  task automatic chk_zero(input string tag);
    chk_exp(tag, '0);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: pending %0d expected 0", tag, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every edge with reset released delivers the product queued before it.
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (nrst && exp_q.size() != 0) chk_exp("mon", exp_q.pop_front());
    end
  end

  initial begin
    logic [7:0] corners[4];
    exp_t       lit;
    corners = '{8'h00, 8'h55, 8'hAA, 8'hFF};
    nrst = 1'b0;
    a = 8'hFF;
    b = 8'hFF;
    #2;
    chk_zero("reset_async");
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      a = 8'($urandom);
      b = 8'($urandom);
      @(posedge CLK);
      #1;
      chk_zero("reset_hold");
    end

    @(negedge CLK);
    nrst = 1'b1;
    apply(8'h00, 8'h00);
    drain("zero");

    // Literal spot checks against the hand-computed values.
    @(negedge CLK);
    a = 8'hFF;
    b = 8'hFF;
    @(posedge CLK);
    #1;
    lit = '{r: 16'hFE01, i4_1: 8'hE1, i4_0: 8'hE1, i2_3: 4'h9, i2_2: 4'h9, i2_1: 4'h9,
            i2_0: 4'h9};
    chk_exp("lit_ff_ff", lit);
    @(negedge CLK);
    a = 8'hA0;
    b = 8'hFF;
    @(posedge CLK);
    #1;
    lit = '{r: 16'h9F60, i4_1: 8'h96, i4_0: 8'h00, i2_3: 4'h6, i2_2: 4'h6, i2_1: 4'h0,
            i2_0: 4'h0};
    chk_exp("lit_a0_ff", lit);

    // Back-to-back through the scoreboard.
    apply(8'hFF, 8'hFF);
    apply(8'hA0, 8'hFF);
    apply(8'hFF, 8'hFF);
    drain("b2b");

    // Mid-cycle asynchronous reset while results are held.
    @(posedge CLK);
    #3;
    nrst = 1'b0;
    #1;
    chk_zero("reset_mid");
    @(negedge CLK);
    nrst = 1'b1;
    a = 8'h12;
    b = 8'h34;
    @(posedge CLK);
    #1;
    lit = '{r: 16'h03A8, i4_1: 8'h03, i4_0: 8'h08, i2_3: 4'h0, i2_2: 4'h3, i2_1: 4'h0,
            i2_0: 4'h0};
    chk_exp("lit_12_34", lit);

    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) apply(corners[i], corners[j]);
    for (int i = 0; i < 1000; i++) apply(8'($urandom), 8'($urandom));
    drain("sweep");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eight_bit_multiplier.md
Name: eight_bit_multiplier

Overview:
Registered SIMD unsigned multiplier. Computes three views of the same 8-bit operand pair in parallel: one full 8x8 product, two independent 4x4 lane products and four independent 2x2 lane products. The 8x8 product is built from the 4x4 lanes, and each 4x4 lane is built from 2x2 sub-products. Serves as a precision-configurable MAC front end (INT8/INT4/INT2) in the SIMD datapath.

Parameters:
None. Widths are fixed: 8-bit operands, 2-bit and 4-bit lanes.

Ports:
CLK  input  1  clock; all state updates on rising edge
nrst  input  1  asynchronous active-low reset
a  input  8  multiplicand, unsigned
b  input  8  multiplier, unsigned
result  output  16  a*b, unsigned 8x8 product
result_int2_0  output  4  a[1:0]*b[1:0]
result_int2_1  output  4  a[3:2]*b[3:2]
result_int2_2  output  4  a[5:4]*b[5:4]
result_int2_3  output  4  a[7:6]*b[7:6]
result_int4_0  output  8  a[3:0]*b[3:0]
result_int4_1  output  8  a[7:4]*b[7:4]

Behaviour:
- Reset: nrst low clears all seven output registers to 0 immediately, with no dependence on CLK. Outputs stay 0 while nrst is low. The first capture occurs on the first rising CLK edge after nrst deasserts.
- Latency: 1 cycle. At each rising CLK edge with nrst high, all outputs register the products of the a/b values present at that edge. There is no handshake and no enable. Throughput is one operand pair per cycle, and back-to-back changes are supported.
- Arithmetic: all operations are unsigned. Products are exact and never truncate: 2x2 fits in 4 bits (max 9), 4x4 fits in 8 bits (max 225), 8x8 fits in 16 bits (max 65025).
- Lane independence: each lane output depends only on its own operand bit slices. Cross-lane carries never leak into lane outputs.
- Structure (required): each 4x4 lane is formed from its four 2x2 sub-products, shifted and added. The 16-bit result is formed from the four 4x4 sub-products: aL*bL + (aH*bL + aL*bH)<<4 + aH*bH<<8. The cross sub-products are internal and not exported. The 2x2 and 4x4 outputs are the same diagonal sub-products used in the composition. All arithmetic is combinational before the single output register stage.
- Unknown inputs: X on a/b may propagate to outputs. No X-masking is required.
- Reset mid-operation: any in-flight product is discarded and outputs go to 0 asynchronously. After release, results reflect operands sampled at the first subsequent rising edge.

Test Plan:
1. Hold nrst=0 with arbitrary a/b and toggle CLK -> all outputs are 0. Release nrst, then apply a=0x00, b=0x00 -> next edge all outputs are 0.
2. a=0xFF, b=0xFF -> one edge later: result=0xFE01, result_int2_0..3=4'h9 each, result_int4_0=result_int4_1=8'hE1.
3. a=0xA0, b=0xFF -> one edge later: result=0x9F60, int2_0=0, int2_1=0, int2_2=6, int2_3=6, int4_0=0x00, int4_1=0x96.
4. Back-to-back: apply test 2 operands, then test 3 operands on the following cycle. Outputs match test 2 then test 3 on consecutive cycles, with no bubble.
5. Assert nrst while valid results are held, mid-cycle between edges -> all outputs go to 0 without a clock edge. Release, present a=0x12, b=0x34 -> next edge: result=0x03A8, int4_0=0x08, int4_1=0x03, int2_0=0, int2_1=0, int2_2=3, int2_3=0.
6. Random sweep of ≥1000 a/b pairs plus exhaustive lane corners (0x00, 0x55, 0xAA, 0xFF) -> every output equals its reference product, compared one cycle delayed.
